// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic {GNT_IF, GNT_D} gnt_t;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-requester round-robin picker
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  gnt_t last_grant,
  output gnt_t gnt,
  output logic gnt_valid
);
  always_comb begin
    gnt = (if_req && d_req) ? ((last_grant == GNT_IF) ? GNT_D : GNT_IF) : (d_req ? GNT_D : GNT_IF);
    gnt_valid = if_req || d_req;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 64,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] memory_addr,
  output logic              memory_rden,
  output logic              memory_wren,
  input  logic [DATA_W-1:0] memory_read_val,
  output logic [DATA_W-1:0] memory_write_val,
  input  logic              memory_response,
  output logic              busy,
  output logic              timeout_err
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t state_q, state_d;
  gnt_t last_q, last_d, arb_gnt;
  logic arb_valid, tmo, fin;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wval_q, wval_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d, rd;
  logic rden_q, rden_d, wren_q, wren_d, if_ack_q, if_ack_d, d_ack_q, d_ack_d;
  logic busy_q, busy_d, err_q, err_d;
  rr_arbiter2 u_rr (
    .if_req    (if_req),
    .d_req     (d_req),
    .last_grant(last_q),
    .gnt       (arb_gnt),
    .gnt_valid (arb_valid)
  );
  // a response on the last allowed cycle wins over the timeout
  assign tmo = (TIMEOUT != 0) && (cnt_q == T_LAST) && !memory_response;
  assign fin = (state_q == S_ACCESS) && (memory_response || tmo);
  assign rd  = memory_response ? memory_read_val : ERR_DATA;
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wval_d     = wval_q;
    rden_d     = rden_q;
    wren_d     = wren_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    err_d      = err_q;
    if_ack_d   = fin && last_q == GNT_IF;
    d_ack_d    = fin && last_q == GNT_D;
    case (state_q)
      S_IDLE: if (arb_valid) begin
        state_d = S_ACCESS;
        last_d  = arb_gnt;
        cnt_d   = '0;
        addr_d  = (arb_gnt == GNT_D) ? d_addr : if_addr;
        wval_d  = (arb_gnt == GNT_D) ? d_wdata : '0;
        wren_d  = (arb_gnt == GNT_D) && d_we;
        rden_d  = !((arb_gnt == GNT_D) && d_we);
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (fin) begin
          state_d    = S_DONE;
          rden_d     = 1'b0;
          wren_d     = 1'b0;
          err_d      = err_q || tmo;
          if_rdata_d = (!wren_q && last_q == GNT_IF) ? rd : if_rdata_q;
          d_rdata_d  = (!wren_q && last_q == GNT_D) ? rd : d_rdata_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      last_q     <= GNT_D;
      cnt_q      <= '0;
      addr_q     <= '0;
      wval_q     <= '0;
      rden_q     <= 1'b0;
      wren_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wval_q     <= wval_d;
      rden_q     <= rden_d;
      wren_q     <= wren_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end
  assign memory_addr      = addr_q;
  assign memory_write_val = wval_q;
  assign memory_rden      = rden_q;
  assign memory_wren      = wren_q;
  assign if_rdata         = if_rdata_q;
  assign d_rdata          = d_rdata_q;
  assign if_ack           = if_ack_q;
  assign d_ack            = d_ack_q;
  assign busy             = busy_q;
  assign timeout_err      = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a wait-state memory model
module tb_mem_port_arbiter;
  logic clk = 0, reset = 1;
  logic if_req = 0, d_req = 0, d_we = 0, memory_response = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, memory_read_val = 0;
  logic [31:0] if_rdata, d_rdata, memory_addr, memory_write_val;
  logic if_ack, d_ack, memory_rden, memory_wren, busy, timeout_err;
  always #5 clk = ~clk;
  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .memory_addr(memory_addr), .memory_rden(memory_rden), .memory_wren(memory_wren),
    .memory_read_val(memory_read_val), .memory_write_val(memory_write_val),
    .memory_response(memory_response), .busy(busy), .timeout_err(timeout_err)
  );
  typedef struct {bit is_d; logic [31:0] rdata;} exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0, bad = 0, cyc = 0, acks = 0, ack_cyc = 0, run = 0, last_len = 0, wait_n = 0;
  logic [31:0] run_addr = 0, last_addr = 0, run_wval = 0, last_wval = 0, rkey = 0;
  bit run_wr = 0, last_wr = 0, resp_en = 1, spur = 0, spur_done = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // memory model and ack monitor, evaluated 1 time unit after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (memory_rden || memory_wren) begin
      chk("strobe_excl", {31'b0, memory_rden & memory_wren}, 0);
      if (run == 0) begin
        run_addr = memory_addr;
        run_wval = memory_write_val;
        run_wr = memory_wren;
      end
      run++;
      memory_response = spur || (resp_en && run == wait_n + 1);
      memory_read_val = memory_addr ^ rkey;
    end else begin
      if (run != 0) begin
        last_len = run;
        last_addr = run_addr;
        last_wval = run_wval;
        last_wr = run_wr;
      end
      run = 0;
      memory_response = spur || (spur_done && (if_ack || d_ack));
      memory_read_val = 32'h5555AAAA;
    end
    if (if_ack || d_ack) begin
      acks++;
      ack_cyc = cyc;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got if_ack=%b d_ack=%b expected no ack", if_ack, d_ack);
      end else begin
        e = q.pop_front();
        chk("ack_id", {30'b0, if_ack, d_ack}, e.is_d ? 32'd1 : 32'd2);
        chk(e.is_d ? "d_rdata" : "if_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
      end
    end
  end
  task automatic do_req(bit is_d, bit we, logic [31:0] addr, logic [31:0] wdata, int wn, bit en,
                        logic [31:0] rval, logic [31:0] exp_rd, int exp_len, int exp_lat);
    int a0, start, n;
    @(negedge clk);
    wait_n = wn;
    resp_en = en;
    rkey = rval ^ addr;
    q.push_back('{is_d, exp_rd});
    a0 = acks;
    start = cyc;
    if (is_d) begin
      d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1; if_addr = addr;
    end
    n = 0;
    while (acks == a0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if_req = 0;
    d_req = 0;
    chk("ack_count", acks - a0, 1);
    if (acks == a0) q.delete();
    chk("latency", ack_cyc - start, exp_lat);
    chk("strobe_len", last_len, exp_len);
    chk("strobe_addr", last_addr, addr);
    chk("strobe_kind", {31'b0, last_wr}, {31'b0, we});
    if (we) chk("write_val", last_wval, wdata);
  endtask
  task automatic wait_acks(int a0, int need);
    int n = 0;
    while (acks < a0 + need && n < 60) begin
      @(negedge clk);
      n++;
    end
    if_req = 0;
    d_req = 0;
    chk("burst_acks", acks - a0, need);
  endtask
  initial begin
    int a0;
    repeat (2) @(negedge clk);
    chk("reset_flags", {26'b0, memory_rden, memory_wren, if_ack, d_ack, busy, timeout_err}, 0);
    chk("reset_addr", memory_addr, 0);
    chk("reset_rdata", if_rdata | d_rdata | memory_write_val, 0);
    reset = 0;
    do_req(0, 0, 32'h10, 0, 0, 1, 32'h8C220004, 32'h8C220004, 1, 2);
    do_req(1, 1, 32'h40, 32'h12345678, 3, 1, 32'h0, 32'h0, 4, 5);
    chk("no_err_on_last_cycle_resp", {31'b0, timeout_err}, 0);
    do_req(1, 0, 32'h80, 0, 0, 0, 32'h0, 32'hDEADBEEF, 4, 5);
    chk("timeout_err_set", {31'b0, timeout_err}, 1);
    do_req(0, 0, 32'h20, 0, 1, 1, 32'h11112222, 32'h11112222, 2, 3);
    do_req(1, 0, 32'h44, 0, 0, 1, 32'hCAFEF00D, 32'hCAFEF00D, 1, 2);
    do_req(1, 1, 32'h48, 32'hA5A5A5A5, 0, 1, 32'h0, 32'hCAFEF00D, 1, 2);
    chk("timeout_err_sticky", {31'b0, timeout_err}, 1);
    a0 = acks;
    @(negedge clk);
    spur = 1;
    repeat (3) @(negedge clk);
    spur = 0;
    repeat (2) @(negedge clk);
    chk("spur_idle_busy", {31'b0, busy}, 0);
    chk("spur_idle_acks", acks - a0, 0);
    chk("spur_idle_if_rdata", if_rdata, 32'h11112222);
    chk("spur_idle_d_rdata", d_rdata, 32'hCAFEF00D);
    spur_done = 1;
    do_req(0, 0, 32'h30, 0, 0, 1, 32'h77778888, 32'h77778888, 1, 2);
    a0 = acks;
    repeat (3) @(negedge clk);
    spur_done = 0;
    chk("spur_done_acks", acks - a0, 0);
    chk("spur_done_busy", {31'b0, busy}, 0);
    chk("spur_done_if_rdata", if_rdata, 32'h77778888);
    @(negedge clk);
    reset = 1;
    if_req = 1; d_req = 1; d_we = 0; if_addr = 32'h100; d_addr = 32'h200;
    wait_n = 0; resp_en = 1; rkey = 32'h0F0F0000;
    @(negedge clk);
    chk("reset_clears_err", {31'b0, timeout_err}, 0);
    q.push_back('{0, 32'h0F0F0100});
    q.push_back('{1, 32'h0F0F0200});
    q.push_back('{0, 32'h0F0F0100});
    q.push_back('{1, 32'h0F0F0200});
    a0 = acks;
    reset = 0;
    wait_acks(a0, 4);
    @(negedge clk);
    resp_en = 0;
    if_req = 1;
    if_addr = 32'h300;
    repeat (2) @(negedge clk);
    chk("rden_before_reset", {31'b0, memory_rden}, 1);
    reset = 1;
    #1;
    chk("rden_async_drop", {31'b0, memory_rden}, 0);
    chk("busy_async_drop", {31'b0, busy}, 0);
    d_req = 1; d_we = 0; d_addr = 32'h400; resp_en = 1; rkey = 32'h12340000;
    q.push_back('{0, 32'h12340300});
    q.push_back('{1, 32'h12340400});
    a0 = acks;
    repeat (2) @(negedge clk);
    chk("no_ack_in_reset", acks - a0, 0);
    reset = 0;
    wait_acks(a0, 2);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
